// File: rtl/bdb_stim_sequencer.sv
// bdb_stim_sequencer: queued button/reset stimulus player for debouncer DUTs.
// Ops are buffered in a FIFO and replayed cycle-accurately, optionally with bounce.
module bdb_stim_sequencer #(
    parameter int N_CHAN   = 4,
    parameter int DEPTH    = 4,
    parameter int WAIT_W   = 8,
    parameter int HOLD_W   = 8,
    parameter int BOUNCE_W = 4,
    parameter int CH_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [1:0]                 op_code,
    input  logic [CH_W-1:0]            op_chan,
    input  logic [WAIT_W-1:0]          op_waits,
    input  logic [HOLD_W-1:0]          op_hold,
    input  logic [BOUNCE_W-1:0]        op_bounce,
    output logic [N_CHAN-1:0]          button,
    output logic                       dut_reset,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       chan_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_PRESS = 2'd1;
    localparam logic [1:0] OP_RST   = 2'd2;
    localparam logic [1:0] OP_BNC   = 2'd3;

    typedef struct packed {
        logic [1:0]          code;
        logic [CH_W-1:0]     chan;
        logic [WAIT_W-1:0]   waits;
        logic [HOLD_W-1:0]   hold;
        logic [BOUNCE_W-1:0] bounce;
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BOUNCE,
        S_HOLD,
        S_REL
    } state_t;

    op_t            mem [DEPTH];
    op_t            in_op;
    op_t            head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic           push;
    logic           pop;

    state_t               state;
    state_t               state_n;
    logic [1:0]           cur_code;
    logic [1:0]           cur_code_n;
    logic [CH_W-1:0]      cur_chan;
    logic [CH_W-1:0]      cur_chan_n;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [WAIT_W-1:0]    wait_n;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [HOLD_W-1:0]    hold_n;
    logic [BOUNCE_W-1:0]  bnc_cnt;
    logic [BOUNCE_W-1:0]  bnc_n;
    logic                 phase;
    logic                 phase_n;
    logic                 err_n;

    logic head_bnc;
    logic cur_bnc;
    logic is_btn;
    logic chan_ok;
    logic line_on;

    assign in_op = '{
        code:   op_code,
        chan:   op_chan,
        waits:  op_waits,
        hold:   op_hold,
        bounce: op_bounce
    };

    assign head     = mem[rd_ptr];
    assign op_ready = (level < LW'(DEPTH));
    assign push     = op_valid && op_ready;
    assign pop      = (state == S_IDLE) && (level != '0);

    // Storage has no reset; only pointers and level define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head_bnc = (head.code == OP_BNC) && (head.bounce != '0);
    assign cur_bnc  = (cur_code == OP_BNC) && (bnc_cnt != '0);
    assign is_btn   = (cur_code == OP_PRESS) || (cur_code == OP_BNC);
    assign chan_ok  = (int'(cur_chan) < N_CHAN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cur_code <= OP_NOP;
            cur_chan <= '0;
            wait_cnt <= '0;
            hold_cnt <= '0;
            bnc_cnt  <= '0;
            phase    <= 1'b0;
            chan_err <= 1'b0;
        end else begin
            state    <= state_n;
            cur_code <= cur_code_n;
            cur_chan <= cur_chan_n;
            wait_cnt <= wait_n;
            hold_cnt <= hold_n;
            bnc_cnt  <= bnc_n;
            phase    <= phase_n;
            chan_err <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_code_n = cur_code;
        cur_chan_n = cur_chan;
        wait_n     = wait_cnt;
        hold_n     = hold_cnt;
        bnc_n      = bnc_cnt;
        phase_n    = phase;
        err_n      = chan_err;
        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    cur_code_n = head.code;
                    cur_chan_n = head.chan;
                    wait_n     = head.waits;
                    hold_n     = head.hold;
                    bnc_n      = head.bounce;
                    phase_n    = 1'b0;
                    if (head.waits != '0) begin
                        state_n = S_WAIT;
                    end else if (head_bnc) begin
                        state_n = S_BOUNCE;
                    end else begin
                        state_n = S_HOLD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_W'(1)) begin
                    state_n = cur_bnc ? S_BOUNCE : S_HOLD;
                end else begin
                    wait_n = wait_cnt - 1'b1;
                end
            end
            // phase 0 drives the line high, phase 1 low
            S_BOUNCE: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else if (bnc_cnt == BOUNCE_W'(1)) begin
                    state_n = S_HOLD;
                end else begin
                    bnc_n   = bnc_cnt - 1'b1;
                    phase_n = 1'b0;
                end
            end
            // a zero hold still lasts one cycle
            S_HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_n = S_REL;
                end else begin
                    hold_n = hold_cnt - 1'b1;
                end
            end
            S_REL: begin
                state_n = S_IDLE;
                if (is_btn && !chan_ok) begin
                    err_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign line_on = (state == S_HOLD) || ((state == S_BOUNCE) && !phase);

    always_comb begin
        button = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            button[i] = line_on && is_btn && chan_ok && (int'(cur_chan) == i);
        end
    end

    assign dut_reset  = (state == S_HOLD) && (cur_code == OP_RST);
    assign done       = (state == S_REL);
    assign busy       = (state != S_IDLE) || (level != '0);
    assign fifo_level = level;

endmodule

// File: tb/tb_bdb_stim_sequencer.sv
// Directed bench for bdb_stim_sequencer: press, bounce, reset op,
// illegal channel, back-pressure, max counts and reset mid-hold.
module tb_bdb_stim_sequencer;

    localparam int N_CHAN = 4;
    localparam int DEPTH  = 4;
    localparam int CH_W   = 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 op_valid;
    logic                 op_ready;
    logic [1:0]           op_code;
    logic [CH_W-1:0]      op_chan;
    logic [7:0]           op_waits;
    logic [7:0]           op_hold;
    logic [3:0]           op_bounce;
    logic [N_CHAN-1:0]    button;
    logic                 dut_reset;
    logic                 busy;
    logic                 done;
    logic [2:0]           fifo_level;
    logic                 chan_err;

    int tests = 0;
    int fails = 0;

    int  done_q[$];
    int  last_ch = -1;
    bit  multi_hot = 0;

    always #5 clock = ~clock;

    bdb_stim_sequencer #(
        .N_CHAN(N_CHAN),
        .DEPTH(DEPTH),
        .WAIT_W(8),
        .HOLD_W(8),
        .BOUNCE_W(4),
        .CH_W(CH_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_code(op_code),
        .op_chan(op_chan),
        .op_waits(op_waits),
        .op_hold(op_hold),
        .op_bounce(op_bounce),
        .button(button),
        .dut_reset(dut_reset),
        .busy(busy),
        .done(done),
        .fifo_level(fifo_level),
        .chan_err(chan_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] c, input int ch, input int w,
                       input int h, input int b);
        op_valid  = 1'b1;
        op_code   = c;
        op_chan   = CH_W'(ch);
        op_waits  = 8'(w);
        op_hold   = 8'(h);
        op_bounce = 4'(b);
    endtask

    always @(negedge clock) begin
        if ($countones(button) > 1) multi_hot = 1;
        for (int i = 0; i < N_CHAN; i++) begin
            if (button[i]) last_ch = i;
        end
        if (done) done_q.push_back(last_ch);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int guard;
        int acc_at_low;
        int lvl_at_low;
        bit saw_low;
        int hi;
        int first_k;
        int done_k;
        int activity;

        reset     = 1'b1;
        op_valid  = 1'b0;
        op_code   = 2'd0;
        op_chan   = '0;
        op_waits  = '0;
        op_hold   = '0;
        op_bounce = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_button", 32'(button), 0);
        chk("rst_dut_reset", 32'(dut_reset), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_chan_err", 32'(chan_err), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(op_ready), 1);

        // press chan 2, waits 3, hold 5
        put(2'd1, 2, 3, 5, 0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            op_valid = 1'b0;
            chk("press_btn", 32'(button), (k >= 5 && k <= 9) ? 32'h4 : 32'h0);
            chk("press_done", 32'(done), (k == 10) ? 32'd1 : 32'd0);
            chk("press_busy", 32'(busy), (k <= 10) ? 32'd1 : 32'd0);
            if (k <= 2) chk("press_level", 32'(fifo_level), (k == 1) ? 32'd1 : 32'd0);
        end

        // bounce_press chan 0, waits 0, hold 2, bounce 3
        pat = 8'b1101_0101;
        put(2'd3, 0, 0, 2, 3);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            op_valid = 1'b0;
            chk("bnc_btn", 32'(button),
                (k >= 2 && k <= 9) ? 32'(pat[k-2]) : 32'h0);
            chk("bnc_done", 32'(done), (k == 10) ? 32'd1 : 32'd0);
        end

        // reset op, waits 1, hold 3; bounce field ignored
        put(2'd2, 3, 1, 3, 5);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            op_valid = 1'b0;
            chk("rop_dut_reset", 32'(dut_reset), (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
            chk("rop_btn", 32'(button), 0);
            chk("rop_done", 32'(done), (k == 6) ? 32'd1 : 32'd0);
        end

        // press on channel 5 (illegal with 4 channels)
        put(2'd1, 5, 0, 2, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            op_valid = 1'b0;
            chk("ill_btn", 32'(button), 0);
            chk("ill_done", 32'(done), (k == 4) ? 32'd1 : 32'd0);
            if (k != 4) chk("ill_chan_err", 32'(chan_err), (k >= 5) ? 32'd1 : 32'd0);
        end

        // back-pressure: six hold=4 presses back to back
        done_q.delete();
        multi_hot  = 0;
        saw_low    = 0;
        acc_at_low = -1;
        lvl_at_low = -1;
        for (int i = 0; i < 6; i++) begin
            put(2'd1, i % 4, 0, 4, 0);
            guard = 0;
            while (!op_ready && guard < 50) begin
                if (!saw_low) begin
                    saw_low    = 1;
                    acc_at_low = i;
                    lvl_at_low = int'(fifo_level);
                end
                @(negedge clock);
                guard++;
            end
            chk("bp_push_timeout", 32'(guard < 50), 1);
            @(negedge clock);
        end
        op_valid = 1'b0;
        guard = 0;
        while (done_q.size() < 6 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk("bp_done_count", 32'(done_q.size()), 6);
        for (int i = 0; i < done_q.size(); i++) begin
            chk("bp_order", 32'(done_q[i]), 32'(i % 4));
        end
        chk("bp_saw_not_ready", 32'(saw_low), 1);
        chk("bp_accepted_before_full", 32'(acc_at_low), 5);
        chk("bp_level_when_full", 32'(lvl_at_low), 4);
        chk("bp_one_hot", 32'(multi_hot), 0);
        chk("bp_chan_err_sticky", 32'(chan_err), 1);
        repeat (3) @(negedge clock);

        // all-ones waits and hold must not wrap
        put(2'd1, 3, 255, 255, 0);
        hi = 0;
        first_k = -1;
        done_k = -1;
        for (int k = 1; k <= 520; k++) begin
            @(negedge clock);
            op_valid = 1'b0;
            if (button == 4'b1000) begin
                hi++;
                if (first_k < 0) first_k = k;
            end
            if (done) done_k = k;
        end
        chk("max_first_assert", 32'(first_k), 257);
        chk("max_hold_cycles", 32'(hi), 255);
        chk("max_done_cycle", 32'(done_k), 512);

        // reset during the 3rd hold cycle with two ops queued
        put(2'd1, 1, 0, 10, 0);
        @(negedge clock);
        put(2'd1, 3, 0, 1, 0);
        @(negedge clock);
        put(2'd1, 3, 0, 1, 0);
        @(negedge clock);
        op_valid = 1'b0;
        @(negedge clock);
        chk("mid_btn_before", 32'(button), 32'h2);
        chk("mid_level_before", 32'(fifo_level), 2);
        chk("mid_chan_err_before", 32'(chan_err), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_btn_after", 32'(button), 0);
        chk("mid_level_after", 32'(fifo_level), 0);
        chk("mid_busy_after", 32'(busy), 0);
        chk("mid_done_after", 32'(done), 0);
        chk("mid_chan_err_after", 32'(chan_err), 0);
        chk("mid_ready_after", 32'(op_ready), 1);
        activity = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (button != '0 || done || dut_reset || busy) activity++;
        end
        chk("mid_quiet", 32'(activity), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
